// File: rtl/interrupt_sequencer_pkg.sv
// ie_defs: shared definitions for the interrupt/return sequencer.
//   - seq_state_e : sequencer FSM states
//   - req_kind_e  : classification of an accepted request
//   - vector addresses, stack page, 6502 P-register bit indices
//   - entry_status: P value pushed on NMI/BRK entry
package ie_defs;

   localparam logic [15:0] VEC_NMI_ADDR   = 16'hFFFA;
   localparam logic [15:0] VEC_RESET_ADDR = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ_ADDR   = 16'hFFFE;

   localparam logic [7:0] STACK_PAGE = 8'h01;

   localparam int P_C = 0;
   localparam int P_Z = 1;
   localparam int P_I = 2;
   localparam int P_D = 3;
   localparam int P_B = 4;
   localparam int P_R = 5;
   localparam int P_V = 6;
   localparam int P_N = 7;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PASS,
      S_PUSH_PCH,
      S_PUSH_PCL,
      S_PUSH_P,
      S_VEC_LO,
      S_VEC_HI,
      S_PULL_P,
      S_PULL_PCL,
      S_PULL_PCH,
      S_CAP
   } seq_state_e;

   typedef enum logic [1:0] {
      REQ_PASS,
      REQ_ENTRY,
      REQ_RESET,
      REQ_RTI
   } req_kind_e;

   // The pushed copy always has the unused R bit set; B tells software
   // whether it was a BRK (1) or a hardware NMI (0).
   function automatic logic [7:0] entry_status(input logic [7:0] p, input logic is_nmi);
      logic [7:0] r;
      r      = p;
      r[P_R] = 1'b1;
      r[P_B] = ~is_nmi;
      return r;
   endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: groups the execute-stage handshake, the CPU state
// exchange and the memory bus owned by the sequencer while busy.
//   slave  : the sequencer side (drives bus + results)
//   master : the CPU / memory side
interface interrupt_sequencer_if;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_in;
   logic [7:0]  mem_data_out;
   logic        mem_write_en;
   logic        mem_read_en;
   logic        is_break;
   logic        is_rti;
   logic        soft_reset;
   logic [7:0]  ppu_status;
   logic        start;
   logic        done;
   logic        busy;
   logic [15:0] pc_in;
   logic [7:0]  status_in;
   logic [7:0]  stack_in;
   logic [15:0] pc_out;
   logic [7:0]  status_out;
   logic [7:0]  stack_out;
   logic        int_disable;
   logic        halt;

   modport slave (
      input  mem_data_in, is_break, is_rti, soft_reset, ppu_status, start,
             pc_in, status_in, stack_in, halt,
      output mem_addr, mem_data_out, mem_write_en, mem_read_en, done, busy,
             pc_out, status_out, stack_out, int_disable
   );

   modport master (
      output mem_data_in, is_break, is_rti, soft_reset, ppu_status, start,
             pc_in, status_in, stack_in, halt,
      input  mem_addr, mem_data_out, mem_write_en, mem_read_en, done, busy,
             pc_out, status_out, stack_out, int_disable
   );
endinterface

// File: rtl/interrupt_sequencer_nmi.sv
// nmi_edge_latch: remembers a 0->1 edge of the NMI source until the
// sequencer starts NMI entry. Runs every cycle regardless of halt.
//   clk, rst : clock, async active-high reset
//   nmi_src  : raw NMI level (PPU vblank flag)
//   clear    : NMI entry is starting this cycle
//   pending  : an NMI edge is waiting to be serviced
module nmi_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic nmi_src,
   input  logic clear,
   output logic pending
);
   logic prev_q, prev_d;
   logic pending_q, pending_d;

   // A fresh edge in the same cycle as the clear must not be lost, so the
   // set term is ORed in after the clear.
   always_comb begin
      prev_d    = nmi_src;
      pending_d = (nmi_src & ~prev_q) | (pending_q & ~clear);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: responder to the execute FSM's per-instruction
// start pulse. Services soft reset, RTI, pending NMI or BRK by driving the
// memory bus for stack pushes/pulls and vector fetches, or passes CPU state
// through unchanged.
//   clk, rst : clock, async active-high reset
//   bus      : interrupt_sequencer_if.slave (handshake, CPU state, memory bus)
// All bus and result outputs are registered.
module interrupt_sequencer
   import ie_defs::*;
#(
   parameter logic [15:0] VEC_NMI   = VEC_NMI_ADDR,
   parameter logic [15:0] VEC_RESET = VEC_RESET_ADDR,
   parameter logic [15:0] VEC_IRQ   = VEC_IRQ_ADDR,
   parameter int          RD_LAT    = 2
) (
   input logic                  clk,
   input logic                  rst,
   interrupt_sequencer_if.slave bus
);
   localparam logic [7:0] LAT = 8'(RD_LAT);

   seq_state_e  state_q, state_d;
   req_kind_e   kind_q, kind_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  p_q, p_d;
   logic [7:0]  sp_q, sp_d;
   logic [7:0]  push_p_q, push_p_d;
   logic [15:0] vec_q, vec_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  pull_p_q, pull_p_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_data_out_q, mem_data_out_d;
   logic        mem_write_en_q, mem_write_en_d;
   logic        mem_read_en_q, mem_read_en_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [15:0] pc_out_q, pc_out_d;
   logic [7:0]  status_out_q, status_out_d;
   logic [7:0]  stack_out_q, stack_out_d;
   logic        nmi_pending;
   logic        nmi_clear;

   nmi_edge_latch u_nmi (
      .clk     (clk),
      .rst     (rst),
      .nmi_src (bus.ppu_status[P_N]),
      .clear   (nmi_clear),
      .pending (nmi_pending)
   );

   // Each transition loads the bus registers for the state being entered,
   // so a state's strobe is visible exactly during that state's first cycle.
   // Read states stay put for RD_LAT extra cycles (cnt) and capture
   // mem_data_in when cnt reaches zero.
   always_comb begin
      state_d        = state_q;
      kind_d         = kind_q;
      pc_d           = pc_q;
      p_d            = p_q;
      sp_d           = sp_q;
      push_p_d       = push_p_q;
      vec_d          = vec_q;
      lo_d           = lo_q;
      hi_d           = hi_q;
      pull_p_d       = pull_p_q;
      cnt_d          = cnt_q;
      mem_addr_d     = mem_addr_q;
      mem_data_out_d = mem_data_out_q;
      mem_write_en_d = mem_write_en_q;
      mem_read_en_d  = mem_read_en_q;
      done_d         = done_q;
      busy_d         = busy_q;
      pc_out_d       = pc_out_q;
      status_out_d   = status_out_q;
      stack_out_d    = stack_out_q;
      nmi_clear      = 1'b0;

      if (!bus.halt) begin
         mem_write_en_d = 1'b0;
         mem_read_en_d  = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  done_d = 1'b0;
                  pc_d   = bus.pc_in;
                  p_d    = bus.status_in;
                  sp_d   = bus.stack_in;
                  if (bus.soft_reset) begin
                     kind_d        = REQ_RESET;
                     sp_d          = bus.stack_in - 8'd3;
                     vec_d         = VEC_RESET;
                     busy_d        = 1'b1;
                     mem_addr_d    = VEC_RESET;
                     mem_read_en_d = 1'b1;
                     cnt_d         = LAT;
                     state_d       = S_VEC_LO;
                  end else if (bus.is_rti) begin
                     kind_d        = REQ_RTI;
                     sp_d          = bus.stack_in + 8'd1;
                     busy_d        = 1'b1;
                     mem_addr_d    = {STACK_PAGE, bus.stack_in + 8'd1};
                     mem_read_en_d = 1'b1;
                     cnt_d         = LAT;
                     state_d       = S_PULL_P;
                  end else if (nmi_pending || bus.is_break) begin
                     kind_d         = REQ_ENTRY;
                     nmi_clear      = nmi_pending;
                     vec_d          = nmi_pending ? VEC_NMI : VEC_IRQ;
                     push_p_d       = entry_status(bus.status_in, nmi_pending);
                     busy_d         = 1'b1;
                     mem_addr_d     = {STACK_PAGE, bus.stack_in};
                     mem_data_out_d = bus.pc_in[15:8];
                     mem_write_en_d = 1'b1;
                     state_d        = S_PUSH_PCH;
                  end else begin
                     kind_d  = REQ_PASS;
                     state_d = S_PASS;
                  end
               end
            end
            S_PASS: begin
               pc_out_d     = pc_q;
               status_out_d = p_q;
               stack_out_d  = sp_q;
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end
            S_PUSH_PCH: begin
               sp_d           = sp_q - 8'd1;
               mem_addr_d     = {STACK_PAGE, sp_q - 8'd1};
               mem_data_out_d = pc_q[7:0];
               mem_write_en_d = 1'b1;
               state_d        = S_PUSH_PCL;
            end
            S_PUSH_PCL: begin
               sp_d           = sp_q - 8'd1;
               mem_addr_d     = {STACK_PAGE, sp_q - 8'd1};
               mem_data_out_d = push_p_q;
               mem_write_en_d = 1'b1;
               state_d        = S_PUSH_P;
            end
            S_PUSH_P: begin
               sp_d           = sp_q - 8'd1;
               mem_addr_d     = vec_q;
               mem_data_out_d = 8'h00;
               mem_read_en_d  = 1'b1;
               cnt_d          = LAT;
               state_d        = S_VEC_LO;
            end
            S_VEC_LO: begin
               if (cnt_q == 8'd0) begin
                  lo_d          = bus.mem_data_in;
                  mem_addr_d    = vec_q + 16'd1;
                  mem_read_en_d = 1'b1;
                  cnt_d         = LAT;
                  state_d       = S_VEC_HI;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            S_VEC_HI: begin
               if (cnt_q == 8'd0) begin
                  hi_d    = bus.mem_data_in;
                  state_d = S_CAP;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            S_PULL_P: begin
               if (cnt_q == 8'd0) begin
                  pull_p_d      = bus.mem_data_in;
                  sp_d          = sp_q + 8'd1;
                  mem_addr_d    = {STACK_PAGE, sp_q + 8'd1};
                  mem_read_en_d = 1'b1;
                  cnt_d         = LAT;
                  state_d       = S_PULL_PCL;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            S_PULL_PCL: begin
               if (cnt_q == 8'd0) begin
                  lo_d          = bus.mem_data_in;
                  sp_d          = sp_q + 8'd1;
                  mem_addr_d    = {STACK_PAGE, sp_q + 8'd1};
                  mem_read_en_d = 1'b1;
                  cnt_d         = LAT;
                  state_d       = S_PULL_PCH;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            S_PULL_PCH: begin
               if (cnt_q == 8'd0) begin
                  hi_d    = bus.mem_data_in;
                  state_d = S_CAP;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            S_CAP: begin
               pc_out_d    = {hi_q, lo_q};
               stack_out_d = sp_q;
               // RTI keeps the live B/R bits; everything else masks interrupts.
               if (kind_q == REQ_RTI) begin
                  status_out_d = (pull_p_q & 8'hCF) | (p_q & 8'h30);
               end else begin
                  status_out_d = p_q | 8'h04;
               end
               mem_addr_d     = 16'h0000;
               mem_data_out_d = 8'h00;
               done_d         = 1'b1;
               busy_d         = 1'b0;
               state_d        = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         kind_q         <= REQ_PASS;
         pc_q           <= 16'h0000;
         p_q            <= 8'h00;
         sp_q           <= 8'h00;
         push_p_q       <= 8'h00;
         vec_q          <= 16'h0000;
         lo_q           <= 8'h00;
         hi_q           <= 8'h00;
         pull_p_q       <= 8'h00;
         cnt_q          <= 8'h00;
         mem_addr_q     <= 16'h0000;
         mem_data_out_q <= 8'h00;
         mem_write_en_q <= 1'b0;
         mem_read_en_q  <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
         pc_out_q       <= 16'h0000;
         status_out_q   <= 8'h04;
         stack_out_q    <= 8'hFF;
      end else begin
         state_q        <= state_d;
         kind_q         <= kind_d;
         pc_q           <= pc_d;
         p_q            <= p_d;
         sp_q           <= sp_d;
         push_p_q       <= push_p_d;
         vec_q          <= vec_d;
         lo_q           <= lo_d;
         hi_q           <= hi_d;
         pull_p_q       <= pull_p_d;
         cnt_q          <= cnt_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_out_q <= mem_data_out_d;
         mem_write_en_q <= mem_write_en_d;
         mem_read_en_q  <= mem_read_en_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
         pc_out_q       <= pc_out_d;
         status_out_q   <= status_out_d;
         stack_out_q    <= stack_out_d;
      end
   end

   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_data_out = mem_data_out_q;
   assign bus.mem_write_en = mem_write_en_q;
   assign bus.mem_read_en  = mem_read_en_q;
   assign bus.done         = done_q;
   assign bus.busy         = busy_q;
   assign bus.pc_out       = pc_out_q;
   assign bus.status_out   = status_out_q;
   assign bus.stack_out    = stack_out_q;
   assign bus.int_disable  = status_out_q[P_I];
endmodule
